// File: rtl/iob_pbus_split_n_pkg.sv
// Shared definitions for the IOB peripheral-bus splitter: FSM state encoding
// and the default read data returned on error responses.
package iob_pbus_split_n_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_READY  = 2'd1,
    WAIT_RVALID = 2'd2,
    ERR_RVALID  = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/iob_pbus_split_n_tmr.sv
// Wait-state watchdog for the splitter: a down-counter reloaded on clr and
// decremented while en is high; expired flags the terminal count.
module iob_pbus_split_n_tmr #(
  parameter int TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic cke_i,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt <= '0;
    end else if (cke_i) begin
      if (clr) begin
        cnt <= TC_LOAD;
      end else if (en && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Remaining count reaches zero on the TIMEOUT-th consecutive wait cycle.
  assign expired = en && (cnt == '0);

endmodule

// File: rtl/iob_pbus_split_n.sv
// One-subordinate to N-manager IOB splitter routed by the address MSBs.
// Define IOB_PBUS_SPLIT_N_TIMEOUT_EN to abort stalled transfers after TIMEOUT cycles.
module iob_pbus_split_n
  import iob_pbus_split_n_pkg::*;
#(
  parameter int                N        = 4,
  parameter int                ADDR_W   = 14,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF),
  parameter int                TIMEOUT  = 256
) (
  input  logic                                   clk_i,
  input  logic                                   arst_n_i,
  input  logic                                   cke_i,
  input  logic                                   s_iob_valid_i,
  input  logic [ADDR_W-1:0]                      s_iob_addr_i,
  input  logic [DATA_W-1:0]                      s_iob_wdata_i,
  input  logic [DATA_W/8-1:0]                    s_iob_wstrb_i,
  output logic                                   s_iob_ready_o,
  output logic                                   s_iob_rvalid_o,
  output logic [DATA_W-1:0]                      s_iob_rdata_o,
  output logic [N-1:0]                           m_iob_valid_o,
  output logic [N*(ADDR_W-$clog2(N))-1:0]        m_iob_addr_o,
  output logic [N*DATA_W-1:0]                    m_iob_wdata_o,
  output logic [N*DATA_W/8-1:0]                  m_iob_wstrb_o,
  input  logic [N-1:0]                           m_iob_ready_i,
  input  logic [N-1:0]                           m_iob_rvalid_i,
  input  logic [N*DATA_W-1:0]                    m_iob_rdata_i,
  output logic                                   err_o
);

  localparam int SEL_W  = $clog2(N);
  localparam int M_AW   = ADDR_W - SEL_W;
  localparam int STRB_W = DATA_W / 8;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel, sel_reg, sel_nxt, port;
  logic             mapped, is_read, tmo;
  logic             fwd, s_ready, s_rvalid, err;
  logic             p_ready, p_rvalid;
  logic [DATA_W-1:0] p_rdata;

  assign sel     = s_iob_addr_i[ADDR_W-1 -: SEL_W];
  assign mapped  = int'(sel) < N;
  assign is_read = ~|s_iob_wstrb_i;
  assign port    = (state == IDLE) ? sel : sel_reg;

`ifdef IOB_PBUS_SPLIT_N_TIMEOUT_EN
  logic in_wait;

  assign in_wait = (state == WAIT_READY) || (state == WAIT_RVALID);

  iob_pbus_split_n_tmr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .en       (in_wait),
    .clr      (!in_wait),
    .expired  (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  // Response-side mux; an unmapped port matches no slice and reads as zero.
  always_comb begin
    p_ready  = 1'b0;
    p_rvalid = 1'b0;
    p_rdata  = '0;
    for (int k = 0; k < N; k++) begin
      if (port == SEL_W'(k)) begin
        p_ready  = m_iob_ready_i[k];
        p_rvalid = m_iob_rvalid_i[k];
        p_rdata  = m_iob_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_reg;
    fwd       = 1'b0;
    s_ready   = 1'b0;
    s_rvalid  = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (!mapped) begin
          s_ready = 1'b1;
          if (s_iob_valid_i) begin
            err = 1'b1;
            if (is_read) state_nxt = ERR_RVALID;
          end
        end else begin
          fwd     = 1'b1;
          s_ready = p_ready;
          if (s_iob_valid_i) begin
            sel_nxt = sel;
            if (!p_ready) begin
              state_nxt = WAIT_READY;
            end else if (is_read) begin
              if (p_rvalid) s_rvalid = 1'b1;
              else          state_nxt = WAIT_RVALID;
            end
          end
        end
      end
      WAIT_READY: begin
        if (tmo) begin
          s_ready   = 1'b1;
          err       = 1'b1;
          state_nxt = (s_iob_valid_i && is_read) ? ERR_RVALID : IDLE;
        end else begin
          fwd     = 1'b1;
          s_ready = p_ready;
          if (s_iob_valid_i && p_ready) begin
            if (!is_read) begin
              state_nxt = IDLE;
            end else if (p_rvalid) begin
              s_rvalid  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = WAIT_RVALID;
            end
          end
        end
      end
      WAIT_RVALID: begin
        // A genuine response wins over a same-cycle timeout.
        if (p_rvalid) begin
          s_rvalid  = 1'b1;
          state_nxt = IDLE;
        end else if (tmo) begin
          err       = 1'b1;
          state_nxt = ERR_RVALID;
        end
      end
      ERR_RVALID: begin
        s_rvalid  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_iob_valid_o = '0;
    m_iob_addr_o  = '0;
    m_iob_wdata_o = '0;
    m_iob_wstrb_o = '0;
    for (int k = 0; k < N; k++) begin
      if (fwd && (port == SEL_W'(k))) begin
        m_iob_valid_o[k]                  = s_iob_valid_i;
        m_iob_addr_o[k*M_AW +: M_AW]      = s_iob_addr_i[M_AW-1:0];
        m_iob_wdata_o[k*DATA_W +: DATA_W] = s_iob_wdata_i;
        m_iob_wstrb_o[k*STRB_W +: STRB_W] = s_iob_wstrb_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state   <= IDLE;
      sel_reg <= '0;
    end else if (cke_i) begin
      state   <= state_nxt;
      sel_reg <= sel_nxt;
    end
  end

  assign s_iob_ready_o  = arst_n_i && s_ready;
  assign s_iob_rvalid_o = arst_n_i && s_rvalid;
  assign err_o          = arst_n_i && err;
  assign s_iob_rdata_o  = (state == ERR_RVALID) ? ERR_DATA : p_rdata;

endmodule

// File: tb/tb_iob_pbus_split_n.sv
// Randomized bench for iob_pbus_split_n: an N=4 and an N=3 instance, plus a
// TIMEOUT=8 instance when IOB_PBUS_SPLIT_N_TIMEOUT_EN is defined.
module tb_iob_pbus_split_n;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int MAW = 12;
  localparam logic [DW-1:0] ERRD = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cke = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_wdata = '0;
  logic [3:0]    s_wstrb = '0;
  logic          s_valid4 = 1'b0, s_valid3 = 1'b0;
  logic [3:0]    m_ready = '0, m_rvalid = '0;
  logic [4*DW-1:0] m_rdata = '0;

  logic d4_ready, d4_rvalid, d4_err;
  logic [DW-1:0] d4_rdata;
  logic [3:0] d4_mvalid;
  logic [4*MAW-1:0] d4_maddr;
  logic [4*DW-1:0] d4_mwdata;
  logic [15:0] d4_mwstrb;

  logic d3_ready, d3_rvalid, d3_err;
  logic [DW-1:0] d3_rdata;
  logic [2:0] d3_mvalid;
  logic [3*MAW-1:0] d3_maddr;
  logic [3*DW-1:0] d3_mwdata;
  logic [11:0] d3_mwstrb;

  iob_pbus_split_n #(.N(4), .ADDR_W(AW), .DATA_W(DW)) u_dut4 (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke),
    .s_iob_valid_i(s_valid4), .s_iob_addr_i(s_addr), .s_iob_wdata_i(s_wdata), .s_iob_wstrb_i(s_wstrb),
    .s_iob_ready_o(d4_ready), .s_iob_rvalid_o(d4_rvalid), .s_iob_rdata_o(d4_rdata),
    .m_iob_valid_o(d4_mvalid), .m_iob_addr_o(d4_maddr), .m_iob_wdata_o(d4_mwdata), .m_iob_wstrb_o(d4_mwstrb),
    .m_iob_ready_i(m_ready), .m_iob_rvalid_i(m_rvalid), .m_iob_rdata_i(m_rdata),
    .err_o(d4_err)
  );

  iob_pbus_split_n #(.N(3), .ADDR_W(AW), .DATA_W(DW)) u_dut3 (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke),
    .s_iob_valid_i(s_valid3), .s_iob_addr_i(s_addr), .s_iob_wdata_i(s_wdata), .s_iob_wstrb_i(s_wstrb),
    .s_iob_ready_o(d3_ready), .s_iob_rvalid_o(d3_rvalid), .s_iob_rdata_o(d3_rdata),
    .m_iob_valid_o(d3_mvalid), .m_iob_addr_o(d3_maddr), .m_iob_wdata_o(d3_mwdata), .m_iob_wstrb_o(d3_mwstrb),
    .m_iob_ready_i(m_ready[2:0]), .m_iob_rvalid_i(m_rvalid[2:0]), .m_iob_rdata_i(m_rdata[3*DW-1:0]),
    .err_o(d3_err)
  );

`ifdef IOB_PBUS_SPLIT_N_TIMEOUT_EN
  logic s_valid_t = 1'b0;
  logic dt_ready, dt_rvalid, dt_err;
  logic [DW-1:0] dt_rdata;
  logic [3:0] dt_mvalid;
  logic [4*MAW-1:0] dt_maddr;
  logic [4*DW-1:0] dt_mwdata;
  logic [15:0] dt_mwstrb;

  iob_pbus_split_n #(.N(4), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) u_dutt (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke),
    .s_iob_valid_i(s_valid_t), .s_iob_addr_i(s_addr), .s_iob_wdata_i(s_wdata), .s_iob_wstrb_i(s_wstrb),
    .s_iob_ready_o(dt_ready), .s_iob_rvalid_o(dt_rvalid), .s_iob_rdata_o(dt_rdata),
    .m_iob_valid_o(dt_mvalid), .m_iob_addr_o(dt_maddr), .m_iob_wdata_o(dt_mwdata), .m_iob_wstrb_o(dt_mwstrb),
    .m_iob_ready_i(m_ready), .m_iob_rvalid_i(m_rvalid), .m_iob_rdata_i(m_rdata),
    .err_o(dt_err)
  );
`endif

  // Observation mux onto the instance under test (0: N=4, 1: N=3, 2: timeout build)
  int dut_sel = 0;
  logic o_ready, o_rvalid, o_err;
  logic [DW-1:0] o_rdata;
  logic [3:0] o_mvalid;
  logic [4*MAW-1:0] o_maddr;
  logic [4*DW-1:0] o_mwdata;
  logic [15:0] o_mwstrb;

  always_comb begin
    o_ready = d4_ready; o_rvalid = d4_rvalid; o_err = d4_err; o_rdata = d4_rdata;
    o_mvalid = d4_mvalid; o_maddr = d4_maddr; o_mwdata = d4_mwdata; o_mwstrb = d4_mwstrb;
    if (dut_sel == 1) begin
      o_ready = d3_ready; o_rvalid = d3_rvalid; o_err = d3_err; o_rdata = d3_rdata;
      o_mvalid = {1'b0, d3_mvalid}; o_maddr = {{MAW{1'b0}}, d3_maddr};
      o_mwdata = {{DW{1'b0}}, d3_mwdata}; o_mwstrb = {4'b0, d3_mwstrb};
    end
`ifdef IOB_PBUS_SPLIT_N_TIMEOUT_EN
    if (dut_sel == 2) begin
      o_ready = dt_ready; o_rvalid = dt_rvalid; o_err = dt_err; o_rdata = dt_rdata;
      o_mvalid = dt_mvalid; o_maddr = dt_maddr; o_mwdata = dt_mwdata; o_mwstrb = dt_mwstrb;
    end
`endif
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_valid(input bit v);
    s_valid4 = v && (dut_sel == 0);
    s_valid3 = v && (dut_sel == 1);
`ifdef IOB_PBUS_SPLIT_N_TIMEOUT_EN
    s_valid_t = v && (dut_sel == 2);
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: request lands only on port sel with the low address bits.
  task automatic check_fwd(input string tag, input bit active, input int sel, input bit full);
    logic [3:0]       ev;
    logic [4*MAW-1:0] ea;
    logic [4*DW-1:0]  ed;
    logic [15:0]      es;
    ev = '0; ea = '0; ed = '0; es = '0;
    if (active) begin
      ev[sel] = 1'b1;
      ea[sel*MAW +: MAW] = s_addr[MAW-1:0];
      ed[sel*DW +: DW] = s_wdata;
      es[sel*4 +: 4] = s_wstrb;
    end
    chk({tag, "/m_valid"}, 128'(o_mvalid), 128'(ev));
    if (full) begin
      chk({tag, "/m_addr"}, 128'(o_maddr), 128'(ea));
      chk({tag, "/m_wdata"}, o_mwdata, ed);
      chk({tag, "/m_wstrb"}, 128'(o_mwstrb), 128'(es));
    end
  endtask

  task automatic err_rsp_cycle(input string tag);
    m_ready = '0; m_rvalid = '0;
    @(negedge clk);
    chk({tag, "/err_rvalid"}, 128'(o_rvalid), 128'(1));
    chk({tag, "/err_rdata"}, 128'(o_rdata), 128'(ERRD));
    chk({tag, "/err_ready"}, 128'(o_ready), 128'(0));
    chk({tag, "/err_pulse"}, 128'(o_err), 128'(0));
    check_fwd({tag, "/err"}, 1'b0, 0, 1'b0);
    next_cycle();
  endtask

  // One transfer: rdy_dly/rv_dly are manager latencies (large = never).
  task automatic txn(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [3:0] wstrb, input int rdy_dly, input int rv_dly,
                     input logic [DW-1:0] rdata);
    int  n, tmo, sel, c, c_acc;
    bit  mapped, rd, acc, expd, exp_rv, exp_t;
    n      = (dut_sel == 1) ? 3 : 4;
    tmo    = (dut_sel == 2) ? 8 : 100000;
    sel    = int'(addr[AW-1 -: 2]);
    mapped = sel < n;
    rd     = (wstrb == 4'h0);
    c = 0; c_acc = 0; acc = 0; expd = 0;
    s_addr = addr; s_wdata = wdata; s_wstrb = wstrb;
    drive_valid(1'b1);
    while (!acc && !expd) begin
      m_ready = '0; m_rvalid = '0;
      m_rdata = {$urandom, $urandom, $urandom, $urandom};
      expd = mapped && (c > 0) && (c == tmo);
      acc  = !mapped || (!expd && (c == rdy_dly));
      if (mapped && c == rdy_dly) m_ready[sel] = 1'b1;
      exp_rv = acc && mapped && rd && (rv_dly == 0);
      if (exp_rv) begin
        m_rvalid[sel] = 1'b1;
        m_rdata[sel*DW +: DW] = rdata;
      end
      @(negedge clk);
      check_fwd({tag, "/req"}, mapped && !expd, sel, !expd);
      chk({tag, "/ready"}, 128'(o_ready), 128'(acc || expd));
      chk({tag, "/err"}, 128'(o_err), 128'(!mapped || expd));
      chk({tag, "/rvalid0"}, 128'(o_rvalid), 128'(exp_rv));
      if (exp_rv) chk({tag, "/rdata0"}, 128'(o_rdata), 128'(rdata));
      c_acc = c;
      next_cycle();
      c++;
      if (c > 60) begin
        chk({tag, "/req_bound"}, 128'(0), 128'(1));
        break;
      end
    end
    drive_valid(1'b0);
    m_ready = '0; m_rvalid = '0;
    if (!rd) return;
    if (!mapped || expd) begin
      err_rsp_cycle(tag);
    end else if (acc && rv_dly > 0) begin
      for (int k = 1; k <= 60; k++) begin
        m_rvalid = '0;
        m_rdata = {$urandom, $urandom, $urandom, $urandom};
        exp_rv = (k == rv_dly);
        exp_t  = !exp_rv && (c_acc + k == tmo);
        if (exp_rv) begin
          m_rvalid[sel] = 1'b1;
          m_rdata[sel*DW +: DW] = rdata;
        end
        @(negedge clk);
        chk({tag, "/rsp_ready"}, 128'(o_ready), 128'(0));
        check_fwd({tag, "/rsp"}, 1'b0, 0, 1'b0);
        chk({tag, "/rsp_rvalid"}, 128'(o_rvalid), 128'(exp_rv));
        chk({tag, "/rsp_err"}, 128'(o_err), 128'(exp_t));
        if (exp_rv) chk({tag, "/rsp_rdata"}, 128'(o_rdata), 128'(rdata));
        next_cycle();
        if (exp_rv) break;
        if (exp_t) begin
          err_rsp_cycle(tag);
          break;
        end
        if (k == 60) chk({tag, "/rsp_bound"}, 128'(0), 128'(1));
      end
      m_rvalid = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ws;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst/ready", 128'(o_ready), 128'(0));
    chk("rst/rvalid", 128'(o_rvalid), 128'(0));
    chk("rst/err", 128'(o_err), 128'(0));
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    dut_sel = 0;
    txn("wr_1004", 14'h1004, 32'hA5A50001, 4'hF, 0, 0, '0);
    txn("rd_p2", 14'h2008, 32'h0, 4'h0, 3, 2, 32'h12345678);
    for (int i = 0; i < 40; i++) begin
      ws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      txn("rnd4", 14'($urandom), $urandom, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    dut_sel = 1;
    txn("n3_rd_unmapped", 14'h3004, 32'h0, 4'h0, 0, 0, '0);
    txn("n3_wr_unmapped", 14'h3ABC, 32'h11112222, 4'h3, 0, 0, '0);
    for (int i = 0; i < 24; i++) begin
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      txn("rnd3", 14'($urandom), $urandom, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Reset in WAIT_RVALID abandons the read; a late rvalid must not leak out.
    dut_sel = 0;
    s_addr = 14'h1010; s_wdata = '0; s_wstrb = 4'h0;
    drive_valid(1'b1);
    m_ready = 4'b0010;
    @(negedge clk);
    chk("rstmid/accept", 128'(o_ready), 128'(1));
    next_cycle();
    drive_valid(1'b0);
    m_ready = '0;
    @(negedge clk);
    chk("rstmid/wait_rvalid", 128'(o_rvalid), 128'(0));
    next_cycle();
    rst_n = 1'b0;
    drive_valid(1'b1);
    m_ready = 4'b0010;
    @(negedge clk);
    chk("rstmid/ready_in_rst", 128'(o_ready), 128'(0));
    chk("rstmid/rvalid_in_rst", 128'(o_rvalid), 128'(0));
    chk("rstmid/err_in_rst", 128'(o_err), 128'(0));
    check_fwd("rstmid/idle_fwd", 1'b1, 1, 1'b1);
    next_cycle();
    rst_n = 1'b1;
    drive_valid(1'b0);
    m_ready = '0;
    m_rvalid = 4'b0010;
    m_rdata[DW +: DW] = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rstmid/late_rvalid", 128'(o_rvalid), 128'(0));
    next_cycle();
    m_rvalid = '0;
    txn("rstmid/after", 14'h1020, 32'h0, 4'h0, 1, 1, 32'hCAFEF00D);

`ifdef IOB_PBUS_SPLIT_N_TIMEOUT_EN
    dut_sel = 2;
    txn("tmo/wr_never", 14'h0040, 32'h55AA55AA, 4'hF, 1000, 0, '0);
    txn("tmo/rd_never", 14'h0044, 32'h0, 4'h0, 1000, 0, '0);
    txn("tmo/rd_rv_never", 14'h0048, 32'h0, 4'h0, 2, 1000, '0);
    txn("tmo/rd_ok", 14'h304C, 32'h0, 4'h0, 1, 2, 32'h0BADCAFE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iob_pbus_split_n.md
IOB_PBUS_SPLIT_N -- requirements
Module: iob_pbus_split_n

Interface
REQ-001 SHALL have parameter N, default 4: number of manager ports, legal 2..16.
REQ-002 SHALL have parameter ADDR_W, default 14: subordinate address width; top SEL_W=$clog2(N) bits select the port.
REQ-003 SHALL have parameter DATA_W, default 32: data width, multiple of 8.
REQ-004 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: rdata returned on error responses.
REQ-005 SHALL have parameter TIMEOUT, default 256: cycles before abort, used only with the macro in REQ-027.
REQ-006 SHALL have one clock, clk_i (input, 1 bit, rising edge), and one reset, arst_n_i (input, 1 bit); reset is asynchronous and active-low.
REQ-007 SHALL have cke_i (input, 1 bit): clock enable; all registers hold when it is low.
REQ-008 SHALL have s_iob_valid_i, s_iob_addr_i[ADDR_W], s_iob_wdata_i[DATA_W] and s_iob_wstrb_i[DATA_W/8] as inputs: the subordinate request.
REQ-009 SHALL have s_iob_ready_o, s_iob_rvalid_o and s_iob_rdata_o[DATA_W] as outputs: the subordinate response.
REQ-010 SHALL have m_iob_valid_o[N], m_iob_addr_o[N*(ADDR_W-SEL_W)], m_iob_wdata_o[N*DATA_W] and m_iob_wstrb_o[N*DATA_W/8] as outputs, flattened with port k at slice k.
REQ-011 SHALL have m_iob_ready_i[N], m_iob_rvalid_i[N] and m_iob_rdata_i[N*DATA_W] as inputs, flattened with port k at slice k.
REQ-012 SHALL have err_o (output, 1 bit): one-cycle pulse on each error response.

Function
REQ-013 SHALL implement the states IDLE, WAIT_READY, WAIT_RVALID and ERR_RVALID.
REQ-014 SHALL, in IDLE, take sel from the addr MSBs combinationally; if sel<N, valid/addr/wdata/wstrb pass only to port sel and s_iob_ready_o=m_iob_ready_i[sel].
REQ-015 SHALL, when valid is high and ready is low in IDLE, go to WAIT_READY and latch sel into sel_reg.
REQ-016 SHALL, on an accepted read (wstrb==0) in any state, go to WAIT_RVALID unless the same-cycle rvalid of the port is high, in which case it returns to IDLE.
REQ-017 SHALL end an accepted write on the ready cycle, and SHALL NOT track write responses.
REQ-018 SHALL, in WAIT_READY, use sel_reg and pass the handshake through; requests that change addr MSBs mid-wait are routed to sel_reg.
REQ-019 SHALL, in WAIT_RVALID, hold s_iob_ready_o=0 and all m_iob_valid_o=0; s_iob_rvalid_o/rdata_o = port sel_reg; rvalid returns to IDLE.
REQ-020 SHALL treat an unmapped sel (sel>=N, possible only when N is not a power of 2) as follows: no manager valid, s_iob_ready_o=1 same cycle, err_o=1; a read goes to ERR_RVALID.
REQ-021 SHALL, in ERR_RVALID, drive s_iob_rvalid_o=1 and s_iob_rdata_o=ERR_DATA for exactly one cycle, hold ready=0, then go to IDLE.
REQ-022 SHALL have no internal latency on the forward path; read latency = manager latency + 0 cycles; an error read completes 1 cycle after acceptance.
REQ-023 SHALL drive non-selected manager slices to 0.

Reset
REQ-024 SHALL, while arst_n_i=0, set state=IDLE, sel_reg=0, err_o=0, the error-rvalid register=0 and the timeout counter=0.
REQ-025 SHALL, during reset, force s_iob_rvalid_o=0 and s_iob_ready_o=0; manager outputs follow the IDLE rules.
REQ-026 SHALL, on reset assertion mid-transaction, abandon the transaction; no response is owed after reset is released.

Configuration
REQ-027 SHALL, with IOB_PBUS_SPLIT_N_TIMEOUT_EN defined, count consecutive cycles spent in WAIT_READY/WAIT_RVALID, clearing the count on entry to IDLE.
REQ-028 SHALL, when the count reaches TIMEOUT-1 in WAIT_READY, drive s_iob_ready_o=1 and manager valid=0 that cycle with err_o=1; a read goes to ERR_RVALID, a write to IDLE.
REQ-029 SHALL, when the count reaches TIMEOUT-1 in WAIT_RVALID, pulse err_o and go to ERR_RVALID; a late manager rvalid afterwards is ignored.
REQ-030 SHALL, without the macro, wait indefinitely, omit the counter, and pulse err_o only for unmapped accesses.

Structure
REQ-031 SHALL place the state encodings and the default ERR_DATA in the shared include iob_pbus_split_n_pkg.
REQ-032 SHALL build the timeout counter as sub-module iob_pbus_split_n_tmr (inputs en/clr, output expired); registers SHALL use the existing iob_reg variants.

Verification
REQ-033 SHALL cover: N=4, write to addr 14'h1004 with m1 ready=1 -> m1 valid and addr 12'h004 in the same cycle, s ready=1, FSM stays IDLE.
REQ-034 SHALL cover: N=4, read to port 2 with ready delayed 3 cycles and rvalid 2 cycles later returning 32'h12345678 -> s_iob_rdata_o=32'h12345678, sel_reg=2 throughout.
REQ-035 SHALL cover: N=3, read to sel=3 -> ready the same cycle, err_o=1, rvalid and 32'hDEADBEEF one cycle later, no m valid.
REQ-036 SHALL cover: TIMEOUT_EN with TIMEOUT=8 and m0 never ready -> ready at the 8th wait cycle, err_o=1, ERR_DATA returned for a read.
REQ-037 SHALL cover: arst_n_i pulsed low in WAIT_RVALID -> IDLE, rvalid=0, a late m rvalid ignored, next transaction correct.
